pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 19 +
 rtl/pipeline_ctrl_sat_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stage indices
// and halt-mode encodings.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;

  localparam int unsigned HALT_MODE_FREEZE = 0;
  localparam int unsigned HALT_MODE_DRAIN  = 1;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// In-order pipeline controller: per-stage stall/flush/valid generation,
// memory-wait and halt/drain sequencing, and stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned HALT_MODE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      halt_req,
  input  logic                      mem_busy,
  input  logic                      cnt_clr,
  input  logic                      branch_taken_e,
  input  logic                      load_e,
  input  logic                      reg_write_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  output logic [NUM_STAGES-1:0]     stall,
  output logic [NUM_STAGES-1:0]     flush,
  output logic [NUM_STAGES-1:0]     valid,
  output logic                      pc_redirect_en,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events
);

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic                  halted_q;
  logic                  global_stall;
  logic                  load_use;
  logic                  branch_flush;

  always_comb begin
    global_stall = (state_q == ST_MEM_WAIT) || (state_q == ST_HALT) || mem_busy;
    load_use     = (state_q == ST_RUN) && valid_q[STG_D] && valid_q[STG_E] &&
                   load_e && reg_write_e && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
    branch_flush = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !global_stall &&
                   valid_q[STG_E] && branch_taken_e;
  end

  // A taken branch squashes the load-use bubble: the dependent op is discarded anyway.
  always_comb begin
    stall = '0;
    flush = '0;
    if (global_stall) begin
      stall = '1;
    end else begin
      if (branch_flush) begin
        flush[STG_D] = 1'b1;
        flush[STG_E] = 1'b1;
      end else if (load_use) begin
        stall[STG_F] = 1'b1;
        stall[STG_D] = 1'b1;
        flush[STG_E] = 1'b1;
      end
      if (state_q == ST_DRAIN) begin
        stall[STG_F] = 1'b1;
        flush[STG_D] = 1'b1;
      end
    end
    pc_redirect_en = branch_flush && !stall[STG_F];
  end

  always_comb begin
    valid_d        = '0;
    valid_d[STG_F] = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (stall[i])      valid_d[i] = valid_q[i];
      else if (flush[i]) valid_d[i] = 1'b0;
      else               valid_d[i] = valid_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy)                                     state_d = ST_MEM_WAIT;
        else if (halt_req && HALT_MODE == HALT_MODE_FREEZE) state_d = ST_HALT;
        else if (halt_req && HALT_MODE == HALT_MODE_DRAIN)  state_d = ST_DRAIN;
      end
      ST_MEM_WAIT: if (!mem_busy) state_d = ST_RUN;
      ST_DRAIN: begin
        if (mem_busy)                               state_d = ST_MEM_WAIT;
        else if (!halt_req)                         state_d = ST_RUN;
        else if (valid_q[NUM_STAGES-1:1] == '0)     state_d = ST_HALT;
      end
      ST_HALT:     if (!halt_req) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign valid  = valid_q;
  assign halted = halted_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (cnt_clr),
    .inc_i   (stall[STG_F] && (state_q != ST_HALT)),
    .count_o (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (cnt_clr),
    .inc_i   (branch_flush),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: instance A (freeze halt, 16-bit counters) and instance B
// (drain halt, 4-bit counters) share one stimulus stream.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt_req = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;
  logic       branch_taken_e = 1'b0, load_e = 1'b0, reg_write_e = 1'b0;
  logic [4:0] rd_e = '0, rs1_d = '0, rs2_d = '0;

  logic [4:0]  a_stall, a_flush, a_valid, b_stall, b_flush, b_valid;
  logic        a_pc, a_halted, b_pc, b_halted;
  logic [15:0] a_scyc, a_fev;
  logic [3:0]  b_scyc, b_fev;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NUM_STAGES(5), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16), .HALT_MODE(0)) u_a (
    .clk(clk), .rst(rst), .halt_req(halt_req), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .branch_taken_e(branch_taken_e), .load_e(load_e), .reg_write_e(reg_write_e),
    .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .stall(a_stall), .flush(a_flush), .valid(a_valid), .pc_redirect_en(a_pc),
    .halted(a_halted), .stall_cycles(a_scyc), .flush_events(a_fev)
  );

  pipeline_ctrl #(.NUM_STAGES(5), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4), .HALT_MODE(1)) u_b (
    .clk(clk), .rst(rst), .halt_req(halt_req), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .branch_taken_e(branch_taken_e), .load_e(load_e), .reg_write_e(reg_write_e),
    .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .stall(b_stall), .flush(b_flush), .valid(b_valid), .pc_redirect_en(b_pc),
    .halted(b_halted), .stall_cycles(b_scyc), .flush_events(b_fev)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    halt_req = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    branch_taken_e = 1'b0; load_e = 1'b0; reg_write_e = 1'b0;
    rd_e = '0; rs1_d = '0; rs2_d = '0;
  endtask

  initial begin
    // Reset with hazard-looking inputs: valid is zero so nothing may fire
    #1 rst = 1'b0;
    branch_taken_e = 1'b1; load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    #1;
    chk("rst_valid",  32'(a_valid),  32'h0);
    chk("rst_stall",  32'(a_stall),  32'h0);
    chk("rst_flush",  32'(a_flush),  32'h0);
    chk("rst_pc",     32'(a_pc),     32'h0);
    chk("rst_halted", 32'(a_halted), 32'h0);
    chk("rst_scyc",   32'(a_scyc),   32'h0);
    chk("rst_fev",    32'(a_fev),    32'h0);
    clr_in();
    @(negedge clk) rst = 1'b1;
    repeat (5) tick();
    chk("fill_valid", 32'(a_valid), 32'h1F);

    // Load-use on rs1
    load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    #1;
    chk("lu_stall", 32'(a_stall), 32'h03);
    chk("lu_flush", 32'(a_flush), 32'h04);
    chk("lu_pc",    32'(a_pc),    32'h0);
    tick();
    chk("lu_scyc",  32'(a_scyc),  32'h1);
    chk("lu_valid", 32'(a_valid), 32'h1B);
    clr_in();
    repeat (5) tick();
    // rd = x0 never creates a hazard
    load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    chk("x0_stall", 32'(a_stall), 32'h0);
    chk("x0_flush", 32'(a_flush), 32'h0);
    tick();
    chk("x0_scyc",  32'(a_scyc),  32'h1);

    // Branch flush
    clr_in();
    branch_taken_e = 1'b1;
    #1;
    chk("br_flush", 32'(a_flush), 32'h06);
    chk("br_stall", 32'(a_stall), 32'h0);
    chk("br_pc",    32'(a_pc),    32'h1);
    tick();
    chk("br_fev",   32'(a_fev),   32'h1);
    chk("br_valid", 32'(a_valid), 32'h19);
    clr_in();
    repeat (2) tick();
    chk("br_refill", 32'(a_valid), 32'h07);
    // Branch plus load-use on rs2: branch wins, no stall
    branch_taken_e = 1'b1; load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    #1;
    chk("brlu_stall", 32'(a_stall), 32'h0);
    chk("brlu_flush", 32'(a_flush), 32'h06);
    chk("brlu_pc",    32'(a_pc),    32'h1);
    tick();
    chk("brlu_fev",   32'(a_fev),   32'h2);

    // Memory busy for three cycles with a pending branch
    clr_in();
    repeat (5) tick();
    mem_busy = 1'b1; branch_taken_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mb_stall", 32'(a_stall), 32'h1F);
      chk("mb_flush", 32'(a_flush), 32'h0);
      chk("mb_pc",    32'(a_pc),    32'h0);
      tick();
    end
    mem_busy = 1'b0;
    // The MEM_WAIT exit cycle still holds the pipe
    #1;
    chk("mbx_stall", 32'(a_stall), 32'h1F);
    chk("mbx_pc",    32'(a_pc),    32'h0);
    tick();
    chk("mb_valid_held", 32'(a_valid), 32'h1F);
    chk("mbr_flush", 32'(a_flush), 32'h06);
    chk("mbr_pc",    32'(a_pc),    32'h1);
    tick();
    chk("mb_scyc", 32'(a_scyc), 32'd5);
    chk("mb_fev",  32'(a_fev),  32'd3);

    // Halt: A freezes at once, B drains
    clr_in();
    repeat (5) tick();
    halt_req = 1'b1;
    #1;
    chk("h_b_stall_run", 32'(b_stall), 32'h0);
    tick();
    chk("h_a_halted", 32'(a_halted), 32'h1);
    chk("h_b_halted", 32'(b_halted), 32'h0);
    chk("h_a_stall",  32'(a_stall),  32'h1F);
    chk("dr_stall",   32'(b_stall),  32'h01);
    chk("dr_flush",   32'(b_flush),  32'h02);
    repeat (4) tick();
    chk("dr_valid",   32'(b_valid),  32'h01);
    chk("dr_halted0", 32'(b_halted), 32'h0);
    tick();
    chk("dr_halted1", 32'(b_halted), 32'h1);
    chk("dr_h_stall", 32'(b_stall),  32'h1F);
    chk("dr_h_flush", 32'(b_flush),  32'h0);
    halt_req = 1'b0;
    tick();
    chk("unh_a", 32'(a_halted), 32'h0);
    chk("unh_b", 32'(b_halted), 32'h0);
    chk("unh_b_stall", 32'(b_stall), 32'h0);

    // Counter saturation and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_b_scyc", 32'(b_scyc), 32'h0);
    chk("clr_b_fev",  32'(b_fev),  32'h0);
    chk("clr_a_scyc", 32'(a_scyc), 32'h0);
    mem_busy = 1'b1;
    repeat (20) tick();
    chk("sat_a_scyc", 32'(a_scyc), 32'd20);
    chk("sat_b_scyc", 32'(b_scyc), 32'd15);
    mem_busy = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clrp_a_scyc", 32'(a_scyc), 32'h0);
    chk("clrp_b_scyc", 32'(b_scyc), 32'h0);

    // Asynchronous reset in the middle of a drain
    repeat (5) tick();
    halt_req = 1'b1;
    repeat (2) tick();
    chk("mid_dr_stall", 32'(b_stall), 32'h01);
    chk("mid_dr_scyc",  32'(b_scyc),  32'h1);
    rst = 1'b0;
    #1;
    chk("ar_valid",  32'(b_valid),  32'h0);
    chk("ar_stall",  32'(b_stall),  32'h0);
    chk("ar_flush",  32'(b_flush),  32'h0);
    chk("ar_pc",     32'(b_pc),     32'h0);
    chk("ar_halted", 32'(b_halted), 32'h0);
    chk("ar_scyc",   32'(b_scyc),   32'h0);
    chk("ar_fev",    32'(b_fev),    32'h0);
    chk("ar_a_halted", 32'(a_halted), 32'h0);
    halt_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    chk("post_rst_stall", 32'(b_stall), 32'h0);
    chk("post_rst_valid", 32'(b_valid), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
